apb_master: RTL and testbench
=============================

# apb_master

APB requester (bridge side) that converts a simple valid/ready command stream into APB3 transfers and returns one response per command. It sits between the testbench or a CPU-side agent and the APB completer memory, driving PSEL/PENABLE/PADDR/PWRITE/PWDATA and sampling PREADY/PRDATA/PSLVERR. A built-in watchdog terminates transfers whose PREADY never arrives.

## Interface
Parameters:
- ADDR_W, 32, PADDR/cmd_addr width
- DATA_W, 32, PWDATA/PRDATA width
- TIMEOUT, 16, max ACCESS cycles before abort; 0 disables watchdog

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PREADY  in  1  completer ready
- PRDATA  in  DATA_W  completer read data
- PSLVERR  in  1  completer error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, PSEL=PENABLE=0. On cmd_valid: latch write/addr/wdata into PWRITE/PADDR/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle, unconditionally -> ACCESS; clear watchdog counter.
- ACCESS: PSEL=1, PENABLE=1. On edge with PREADY=1: capture rsp_rdata=PRDATA (reads) or 0 (writes), rsp_err=PSLVERR, rsp_timeout=0 -> RESP. Else increment counter; if TIMEOUT!=0 and counter reaches TIMEOUT-1 with PREADY=0: rsp_rdata=0, rsp_err=1, rsp_timeout=1 -> RESP.
- RESP: PSEL=PENABLE=0, rsp_valid=1, response registers held stable; on rsp_ready -> IDLE.
- PADDR/PWRITE/PWDATA stable from SETUP through final ACCESS cycle; hold last value in IDLE/RESP.
- cmd_ready=0 in SETUP/ACCESS/RESP; one outstanding transfer only.
- Watchdog counter width $clog2(TIMEOUT+1), saturating, never wraps.
- PSLVERR and PRDATA sampled only in ACCESS with PREADY=1; ignored otherwise.

## Timing
- Reset (edge with PRESET=1): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0; counter=0. cmd_ready=1 from the first cycle after reset; commands presented during PRESET=1 are dropped.
- Reset mid-transfer: PSEL/PENABLE low the next cycle, in-flight response discarded, no rsp_valid.
- Accept at edge N -> SETUP cycle N+1 -> first ACCESS N+2 -> PREADY=1 at edge N+2 gives rsp_valid in cycle N+3.
- Zero-wait transfer with rsp_ready held high: 4 cycles command-to-command (IDLE, SETUP, ACCESS, RESP).
- W wait states extend ACCESS to W+1 cycles; timeout transfer shows exactly TIMEOUT ACCESS cycles.
- PREADY=1 on the timeout cycle: normal completion wins, rsp_timeout=0.
- rsp_ready low: RESP held indefinitely, APB bus idle, cmd_ready=0.
- rsp_ready asserted before rsp_valid has no effect.

## Structure
- Package apb_pkg: typedef enum logic [1:0] apb_state_e {IDLE, SETUP, ACCESS, RESP}; default ADDR_W/DATA_W localparams; response struct (rdata, err, timeout).
- Watchdog as sub-module apb_wdog (clear, enable, TIMEOUT parameter, expired output); the rest is a single FSM module.

## Test plan
- Write addr 0x05 data 0xA5A5_0001, PREADY tied 1 -> PSEL rises N+1, PENABLE N+2, rsp_valid N+3 with rsp_err=0, rsp_rdata=0; completer mem[5]=0xA5A5_0001.
- Read addr 0x05 with 3 wait states -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0xA5A5_0001, rsp_err=0.
- Read addr 40, completer returns PSLVERR=1, PRDATA=0xDEADBEEF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEADBEEF.
- TIMEOUT=16, PREADY stuck 0 -> 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0; TIMEOUT=0 -> ACCESS persists indefinitely.
- rsp_ready held 0 for 5 cycles after rsp_valid -> response stable, cmd_ready=0, PSEL=0 throughout; next command accepted the cycle after rsp_ready rises.
- PRESET pulsed during the second ACCESS cycle -> next cycle PSEL=PENABLE=0, all outputs 0, no rsp_valid; a following write completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths,
// the response record and the watchdog counter sizing helper.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // A disabled watchdog (timeout 0) still gets a 1-bit counter so no zero-width vector appears.
  function automatic int wdog_width(int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB3 bus bundle; master modport is the requester view,
// slave modport is the agent/completer view.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_master_wdog.sv
// ACCESS-phase watchdog: saturating wait counter, expired on the TIMEOUT-th
// waiting cycle; TIMEOUT=0 never expires.
module apb_wdog
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = wdog_width(int'(TIMEOUT));
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    expired_o = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  end

endmodule

// File: rtl/apb_master.sv
// APB3 requester: turns one valid/ready command into one APB transfer and
// returns a single response; the watchdog aborts transfers stuck in ACCESS.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic wd_clear, wd_enable, wd_expired;

  apb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          pwdata_d = bus.cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wd_clear = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion on the last allowed cycle beats the abort.
        if (bus.PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    bus.cmd_ready   = (state_q == IDLE);
    bus.PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    bus.PENABLE     = (state_q == ACCESS);
    bus.PADDR       = paddr_q;
    bus.PWRITE      = pwrite_q;
    bus.PWDATA      = pwdata_q;
    bus.rsp_valid   = (state_q == RESP);
    bus.rsp_rdata   = rsp_rdata_q;
    bus.rsp_err     = rsp_err_q;
    bus.rsp_timeout = rsp_timeout_q;
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: APB completer memory with programmable wait states and an
// error address, plus a transaction-level reference model of the expected responses.
module tb_apb_master;

  localparam int          TMO      = 16;
  localparam int          STUCK    = 1000;
  localparam logic [31:0] ERR_ADDR = 32'd40;

  logic PCLK = 1'b0;
  logic PRESET;
  logic rst0;
  always #5 PCLK = ~PCLK;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );
  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .PCLK(PCLK), .PRESET(rst0), .bus(bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Completer: PREADY after wait_states waiting cycles unless stuck; address 40 errors.
  int          wait_states = 0;
  bit          stuck       = 1'b0;
  int          acc_cnt     = 0;
  logic [31:0] mem    [64];
  bit          mem_wr [64];
  logic [31:0] ref_mem[64];

  function automatic logic [31:0] init_pat(logic [5:0] a);
    return 32'h1357_0000 ^ ({26'd0, a} * 32'h0101_0101);
  endfunction

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && !stuck && (acc_cnt == wait_states);
  assign bus.PSLVERR = (bus.PADDR == ERR_ADDR);
  assign bus.PRDATA  = (bus.PADDR == ERR_ADDR) ? 32'hDEAD_BEEF :
                       (mem_wr[bus.PADDR[5:0]] ? mem[bus.PADDR[5:0]] : init_pat(bus.PADDR[5:0]));

  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (bus.PREADY) begin
        acc_cnt <= 0;
        if (bus.PWRITE && !bus.PSLVERR) begin
          mem[bus.PADDR[5:0]]    <= bus.PWDATA;
          mem_wr[bus.PADDR[5:0]] <= 1'b1;
        end
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  assign bus0.PREADY  = 1'b0;
  assign bus0.PRDATA  = '0;
  assign bus0.PSLVERR = 1'b0;

  // Reference: a transfer waiting W cycles completes after W+1 ACCESS cycles unless that exceeds TMO.
  function automatic apb_pkg::apb_rsp_t model(logic wr, logic [31:0] addr, logic [31:0] wdata, int waits);
    apb_pkg::apb_rsp_t r;
    r = '0;
    if (waits + 1 > TMO) begin
      r.err = 1'b1;
      r.timeout = 1'b1;
    end else if (addr == ERR_ADDR) begin
      r.err = 1'b1;
      if (!wr) r.rdata = 32'hDEAD_BEEF;
    end else if (wr) begin
      ref_mem[addr[5:0]] = wdata;
    end else begin
      r.rdata = ref_mem[addr[5:0]];
    end
    return r;
  endfunction

  function automatic int exp_acc(int waits);
    return (waits + 1 > TMO) ? TMO : waits + 1;
  endfunction

  // Drives one command and observes it; cycle numbers are relative to the accepting edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input int hold,
                      output int t_psel, output int t_pen, output int n_acc, output int t_rsp,
                      output logic [31:0] rdata, output logic err, output logic tmo,
                      output bit addr_stable, output bit hold_ok);
    int k;
    int guard;
    stuck         = (waits >= STUCK);
    wait_states   = waits;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(posedge PCLK); #1;
      guard++;
    end
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    k = 1; t_psel = -1; t_pen = -1; n_acc = 0; addr_stable = 1'b1;
    while (!bus.rsp_valid && k < 60) begin
      if (bus.PSEL && t_psel < 0) t_psel = k;
      if (bus.PENABLE && t_pen < 0) t_pen = k;
      if (bus.PSEL && bus.PENABLE) n_acc++;
      if (bus.PSEL && (bus.PADDR !== addr || bus.PWRITE !== wr || (wr && bus.PWDATA !== wdata)))
        addr_stable = 1'b0;
      @(posedge PCLK); #1;
      k++;
    end
    t_rsp   = bus.rsp_valid ? k : -1;
    rdata   = bus.rsp_rdata;
    err     = bus.rsp_err;
    tmo     = bus.rsp_timeout;
    hold_ok = bus.rsp_valid && !bus.PSEL && !bus.PENABLE && !bus.cmd_ready;
    for (int i = 0; i < hold; i++) begin
      @(posedge PCLK); #1;
      if (!bus.rsp_valid || bus.rsp_rdata !== rdata || bus.rsp_err !== err ||
          bus.rsp_timeout !== tmo || bus.cmd_ready || bus.PSEL || bus.PENABLE)
        hold_ok = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    bus.rsp_ready = 1'b0;
    stuck = 1'b0;
  endtask

  task automatic test_reset();
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'd3;
    bus.cmd_wdata = 32'h1111_2222;
    repeat (3) @(posedge PCLK);
    #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout});
    end
    n_checks++;
    if ({bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected zeros", bus.PADDR, bus.PWDATA, bus.rsp_rdata);
    end
    PRESET        = 1'b0;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
    end
    @(posedge PCLK); #1;
    n_checks++;
    if (bus.PSEL !== 1'b0 || mem_wr[3]) begin
      n_fail++;
      $display("FAIL reset_cmd_dropped: PSEL %b mem_written %b expected 0 0", bus.PSEL, mem_wr[3]);
    end
  endtask

  task automatic test_write_zero_wait();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    apb_pkg::apb_rsp_t e;
    e = model(1'b1, 32'h5, 32'hA5A5_0001, 0);
    xfer(1'b1, 32'h5, 32'hA5A5_0001, 0, 0, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if (tp !== 1 || te !== 2 || tr !== 3) begin
      n_fail++;
      $display("FAIL wr_timing: psel %0d penable %0d rsp %0d expected 1 2 3", tp, te, tr);
    end
    n_checks++;
    if ({rd, er, to} !== e || {rd, er, to} !== 34'd0) begin
      n_fail++;
      $display("FAIL wr_rsp: got %h/%b/%b expected 0/0/0", rd, er, to);
    end
    n_checks++;
    if (mem[5] !== 32'hA5A5_0001 || !mem_wr[5]) begin
      n_fail++;
      $display("FAIL wr_mem: got %h expected a5a50001", mem[5]);
    end
  endtask

  task automatic test_read_wait_states();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    apb_pkg::apb_rsp_t e;
    e = model(1'b0, 32'h5, 32'h0, 3);
    xfer(1'b0, 32'h5, 32'h0, 3, 0, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if (na !== 4 || tr !== 6 || !st) begin
      n_fail++;
      $display("FAIL rd_wait: access %0d rsp %0d stable %b expected 4 6 1", na, tr, st);
    end
    n_checks++;
    if ({rd, er, to} !== e || rd !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL rd_wait_rsp: got %h/%b/%b expected a5a50001/0/0", rd, er, to);
    end
  endtask

  task automatic test_slverr();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    xfer(1'b0, 32'd40, 32'h0, 0, 0, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b1 || to !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_rsp: got %h/%b/%b expected deadbeef/1/0", rd, er, to);
    end
  endtask

  task automatic test_timeout();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    apb_pkg::apb_rsp_t e;
    xfer(1'b1, 32'd20, 32'h7777_7777, STUCK, 1, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if (na !== TMO || tr !== TMO + 2 || !ho) begin
      n_fail++;
      $display("FAIL tmo_len: access %0d rsp %0d bus_idle %b expected %0d %0d 1", na, tr, ho, TMO, TMO + 2);
    end
    n_checks++;
    if ({rd, er, to} !== {32'd0, 1'b1, 1'b1} || mem_wr[20]) begin
      n_fail++;
      $display("FAIL tmo_rsp: got %h/%b/%b written %b expected 0/1/1 0", rd, er, to, mem_wr[20]);
    end
    e = model(1'b0, 32'd9, 32'h0, TMO - 1);
    xfer(1'b0, 32'd9, 32'h0, TMO - 1, 0, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if (na !== TMO || {rd, er, to} !== e || to !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_boundary: access %0d rsp %h/%b/%b expected %0d %h/%b/%b",
               na, rd, er, to, TMO, e.rdata, e.err, e.timeout);
    end
  endtask

  task automatic test_no_timeout();
    bit ok;
    rst0 = 1'b0;
    bus0.cmd_valid = 1'b1;
    bus0.cmd_write = 1'b0;
    bus0.cmd_addr  = 32'd4;
    bus0.cmd_wdata = '0;
    @(posedge PCLK); #1;
    bus0.cmd_valid = 1'b0;
    ok = bus0.PSEL && !bus0.PENABLE;
    for (int k = 2; k < 42; k++) begin
      @(posedge PCLK); #1;
      if (!(bus0.PSEL && bus0.PENABLE) || bus0.rsp_valid) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL no_timeout: got access ended (rsp_valid %b) expected 40 persisting ACCESS cycles",
               bus0.rsp_valid);
    end
    rst0 = 1'b1;
  endtask

  task automatic test_resp_hold();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    apb_pkg::apb_rsp_t e;
    e = model(1'b0, 32'd5, 32'h0, 1);
    xfer(1'b0, 32'd5, 32'h0, 1, 5, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if (!ho || {rd, er, to} !== e) begin
      n_fail++;
      $display("FAIL resp_hold: stable %b rsp %h/%b/%b expected 1 %h/%b/%b",
               ho, rd, er, to, e.rdata, e.err, e.timeout);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL resp_release: cmd_ready %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_mid_reset();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    bit quiet;
    apb_pkg::apb_rsp_t e;
    wait_states   = 5;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'd7;
    bus.cmd_wdata = 32'hCAFE_0007;
    @(posedge PCLK); #1;
    bus.cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    n_checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 6'b0 ||
        {bus.PADDR, bus.PWDATA, bus.rsp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: psel %b pen %b rsp_valid %b paddr %h expected all zero",
               bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.PADDR);
    end
    PRESET = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      if (bus.rsp_valid || bus.PSEL || !bus.cmd_ready) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet || mem_wr[7]) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: idle %b written %b expected 1 0", quiet, mem_wr[7]);
    end
    e = model(1'b1, 32'd7, 32'hBEEF_0707, 0);
    xfer(1'b1, 32'd7, 32'hBEEF_0707, 0, 0, tp, te, na, tr, rd, er, to, st, ho);
    n_checks++;
    if ({rd, er, to} !== e || tr !== 3 || mem[7] !== 32'hBEEF_0707) begin
      n_fail++;
      $display("FAIL mid_reset_follow: rsp %0d mem %h expected 3 beef0707", tr, mem[7]);
    end
  endtask

  task automatic test_back_to_back();
    int acc_t[$];
    apb_pkg::apb_rsp_t expq[$];
    apb_pkg::apb_rsp_t e;
    int nacc = 0;
    int nrsp = 0;
    bit took;
    wait_states   = 0;
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = 32'($urandom_range(0, 63));
    bus.cmd_wdata = $urandom;
    for (int c = 0; c < 80; c++) begin
      if (bus.rsp_valid) begin
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        nrsp++;
        n_checks++;
        if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== e) begin
          n_fail++;
          $display("FAIL b2b_rsp: got %h/%b/%b expected %h/%b/%b", bus.rsp_rdata, bus.rsp_err,
                   bus.rsp_timeout, e.rdata, e.err, e.timeout);
        end
      end
      took = bus.cmd_ready && bus.cmd_valid;
      if (took) begin
        acc_t.push_back(c);
        expq.push_back(model(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, 0));
        nacc++;
      end
      @(posedge PCLK); #1;
      if (took) begin
        if (nacc < 8) begin
          bus.cmd_write = 1'($urandom_range(0, 1));
          bus.cmd_addr  = 32'($urandom_range(0, 63));
          bus.cmd_wdata = $urandom;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      if (nacc == 8 && expq.size() == 0) break;
    end
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (nrsp !== 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d responses expected 8", nrsp);
    end
    for (int i = 1; i < acc_t.size(); i++) begin
      n_checks++;
      if (acc_t[i] - acc_t[i-1] !== 4) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d cycles expected 4", acc_t[i] - acc_t[i-1]);
      end
    end
  endtask

  task automatic test_random();
    int tp, te, na, tr; logic [31:0] rd; logic er, to; bit st, ho;
    apb_pkg::apb_rsp_t e;
    logic wr; logic [31:0] addr, wdata; int waits, hold;
    for (int n = 0; n < 20; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, 63));
      wdata = $urandom;
      waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      hold  = int'($urandom_range(0, 2));
      e = model(wr, addr, wdata, waits);
      xfer(wr, addr, wdata, waits, hold, tp, te, na, tr, rd, er, to, st, ho);
      n_checks++;
      if ({rd, er, to} !== e) begin
        n_fail++;
        $display("FAIL rand_rsp: wr %b addr %0d waits %0d got %h/%b/%b expected %h/%b/%b",
                 wr, addr, waits, rd, er, to, e.rdata, e.err, e.timeout);
      end
      n_checks++;
      if (na !== exp_acc(waits) || tr !== exp_acc(waits) + 2) begin
        n_fail++;
        $display("FAIL rand_timing: waits %0d access %0d rsp %0d expected %0d %0d",
                 waits, na, tr, exp_acc(waits), exp_acc(waits) + 2);
      end
      n_checks++;
      if (!st || !ho || tp !== 1 || te !== 2) begin
        n_fail++;
        $display("FAIL rand_bus: stable %b held %b psel %0d pen %0d expected 1 1 1 2", st, ho, tp, te);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    PRESET = 1'b1;
    rst0   = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_write = 1'b0; bus0.cmd_addr = '0; bus0.cmd_wdata = '0;
    bus0.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_pat(6'(i));
    @(posedge PCLK); #1;
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_slverr();
    test_timeout();
    test_no_timeout();
    test_resp_hold();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
